// File: rtl/fb_scaled_reader.sv
// rtl/fb_scaled_reader.sv - scaled, positioned framebuffer reader with CLUT and aligned VGA outputs
module fb_scaled_reader #(
  parameter int CORDW     = 16,
  parameter int CHANW     = 4,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int FB_DATAW  = 1,
  parameter int SCALE     = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BRAM_LAT  = 1,
  parameter logic [3*CHANW-1:0] BG_COLR = 'h137,
  localparam int COLRW    = 3*CHANW,
  localparam int FB_ADDRW = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic                    de,
  input  logic                    frame,
  input  logic signed [CORDW-1:0] pos_x,
  input  logic signed [CORDW-1:0] pos_y,
  output logic [FB_ADDRW-1:0]     fb_addr_read,
  input  logic [FB_DATAW-1:0]     fb_colr_read,
  input  logic                    clut_we,
  input  logic [FB_DATAW-1:0]     clut_addr,
  input  logic [COLRW-1:0]        clut_data,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [CHANW-1:0]        vga_r,
  output logic [CHANW-1:0]        vga_g,
  output logic [CHANW-1:0]        vga_b
);

  if (FB_DATAW < 1 || FB_DATAW > 8 || SCALE < 1 || SCALE > 8 ||
      BRAM_LAT < 1 || BRAM_LAT > 2) begin : g_bad_params
    $error("fb_scaled_reader: illegal parameter value");
  end

  localparam int CNTW   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CLUT_N = 1 << FB_DATAW;
  localparam logic [CNTW-1:0]     CNT_MAX  = CNTW'(SCALE-1);
  localparam logic [FB_ADDRW-1:0] LINE_INC = FB_ADDRW'(FB_WIDTH);
  localparam logic signed [CORDW:0] WIN_W    = (CORDW+1)'(FB_WIDTH*SCALE);
  localparam logic signed [CORDW:0] WIN_H    = (CORDW+1)'(FB_HEIGHT*SCALE);
  localparam logic signed [CORDW:0] WIN_W_M1 = (CORDW+1)'(FB_WIDTH*SCALE-1);
  localparam logic signed [CORDW:0] H_RES_E  = (CORDW+1)'(H_RES);
  localparam logic signed [CORDW:0] V_RES_E  = (CORDW+1)'(V_RES);
  localparam logic signed [CORDW:0] H_LAST   = (CORDW+1)'(H_RES-1);

  function automatic logic [COLRW-1:0] grey(input int i);
    int c;
    c = (i * ((1 << CHANW) - 1)) / ((1 << FB_DATAW) - 1);
    return {3{CHANW'(c)}};
  endfunction

  logic signed [CORDW-1:0] px_q, px_d, py_q, py_d;
  logic                    armed_q, armed_d;
  logic [FB_ADDRW-1:0]     addr_q, addr_d, line_base_q, line_base_d;
  logic [CNTW-1:0]         cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic [3:0]              dl_q [BRAM_LAT];
  logic [3:0]              dl_d [BRAM_LAT];
  logic [COLRW-1:0]        clut_q [CLUT_N];
  logic [COLRW-1:0]        clut_d [CLUT_N];
  logic                    hs_q, hs_d, vs_q, vs_d;
  logic [COLRW-1:0]        colr_q, colr_d;

  logic signed [CORDW:0] sx_e, sy_e, px_e, py_e;
  logic                  in_win, last_col;
  logic [3:0]            tap;

  // Extents are one bit wider than the coordinates so px+width never wraps.
  always_comb begin
    sx_e = {sx[CORDW-1], sx};
    sy_e = {sy[CORDW-1], sy};
    px_e = {px_q[CORDW-1], px_q};
    py_e = {py_q[CORDW-1], py_q};
    in_win = (sy_e >= py_e) && (sy_e < py_e + WIN_H) && (sy_e < V_RES_E) &&
             (sx_e >= px_e) && (sx_e < px_e + WIN_W) && (sx_e < H_RES_E);
    last_col = (sx_e == px_e + WIN_W_M1) || (sx_e == H_LAST);
  end

  always_comb begin
    px_d        = px_q;
    py_d        = py_q;
    armed_d     = armed_q;
    addr_d      = addr_q;
    line_base_d = line_base_q;
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    if (frame) begin
      px_d        = pos_x;
      py_d        = pos_y;
      armed_d     = 1'b1;
      addr_d      = '0;
      line_base_d = '0;
      cnt_x_d     = '0;
      cnt_y_d     = '0;
    end else if (armed_q && in_win) begin
      if (last_col) begin
        cnt_x_d = '0;
        if (cnt_y_q == CNT_MAX) begin
          cnt_y_d     = '0;
          line_base_d = line_base_q + LINE_INC;
          addr_d      = line_base_q + LINE_INC;
        end else begin
          cnt_y_d = cnt_y_q + CNTW'(1);
          addr_d  = line_base_q;
        end
      end else if (cnt_x_q == CNT_MAX) begin
        cnt_x_d = '0;
        addr_d  = addr_q + FB_ADDRW'(1);
      end else begin
        cnt_x_d = cnt_x_q + CNTW'(1);
      end
    end
  end

  // Timing signals ride alongside the BRAM read; the colour register adds the last stage.
  always_comb begin
    dl_d[0] = {hsync, vsync, de, in_win};
    for (int i = 1; i < BRAM_LAT; i++) dl_d[i] = dl_q[i-1];
    tap  = dl_q[BRAM_LAT-1];
    hs_d = tap[3];
    vs_d = tap[2];
    if (!tap[1])                colr_d = '0;
    else if (tap[0] && armed_q) colr_d = clut_q[fb_colr_read];
    else                        colr_d = BG_COLR;
    clut_d = clut_q;
    if (clut_we) clut_d[clut_addr] = clut_data;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      px_q        <= '0;
      py_q        <= '0;
      armed_q     <= 1'b0;
      addr_q      <= '0;
      line_base_q <= '0;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      for (int i = 0; i < BRAM_LAT; i++) dl_q[i] <= '0;
      for (int i = 0; i < CLUT_N; i++) clut_q[i] <= grey(i);
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      colr_q      <= '0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      armed_q     <= armed_d;
      addr_q      <= addr_d;
      line_base_q <= line_base_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      dl_q        <= dl_d;
      clut_q      <= clut_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      colr_q      <= colr_d;
    end
  end

  assign fb_addr_read = addr_q;
  assign vga_hsync    = hs_q;
  assign vga_vsync    = vs_q;
  assign vga_r        = colr_q[3*CHANW-1 -: CHANW];
  assign vga_g        = colr_q[2*CHANW-1 -: CHANW];
  assign vga_b        = colr_q[CHANW-1 -: CHANW];

endmodule

// File: tb/tb_fb_scaled_reader.sv
// tb/tb_fb_scaled_reader.sv - directed checks of addressing, latency, CLUT, position and reset
module tb_fb_scaled_reader;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic               rst_pix_n;
  logic signed [15:0] sx, sy, pos_x, pos_y, pos_x2, pos_y2;
  logic               hsync, vsync, de, frame;
  logic               clut_we;
  logic [0:0]         clut_addr;
  logic [11:0]        clut_data;

  logic [14:0] fb_addr, fb_addr2;
  logic        fb_colr;
  logic        vga_hs, vga_vs, vga_hs2, vga_vs2;
  logic [3:0]  vga_r, vga_g, vga_b, vga_r2, vga_g2, vga_b2;

  logic mem [0:19199];
  always_ff @(posedge clk_pix) fb_colr <= mem[fb_addr];

  fb_scaled_reader u_dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy),
    .hsync(hsync), .vsync(vsync), .de(de), .frame(frame),
    .pos_x(pos_x), .pos_y(pos_y), .fb_addr_read(fb_addr), .fb_colr_read(fb_colr),
    .clut_we(clut_we), .clut_addr(clut_addr), .clut_data(clut_data),
    .vga_hsync(vga_hs), .vga_vsync(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  fb_scaled_reader #(.SCALE(1)) u_clip (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy),
    .hsync(hsync), .vsync(vsync), .de(de), .frame(frame),
    .pos_x(pos_x2), .pos_y(pos_y2), .fb_addr_read(fb_addr2), .fb_colr_read(1'b0),
    .clut_we(1'b0), .clut_addr(1'b0), .clut_data(12'h000),
    .vga_hsync(vga_hs2), .vga_vsync(vga_vs2), .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return 32'({vga_r, vga_g, vga_b});
  endfunction

  function automatic logic [31:0] rgb2();
    return 32'({vga_r2, vga_g2, vga_b2});
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    sx = 16'(x);
    sy = 16'(y);
    de = 1'b1;
  endtask

  task automatic frame_pulse();
    sx = -16'sd20;
    sy = -16'sd1;
    de = 1'b0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 1'b0;
    mem[0]   = 1'b1;
    mem[3]   = 1'b1;
    mem[160] = 1'b1;
    rst_pix_n = 1'b0;
    sx = '0; sy = '0; hsync = 1'b0; vsync = 1'b0; de = 1'b0; frame = 1'b0;
    pos_x = '0; pos_y = '0; pos_x2 = 16'sd600; pos_y2 = 16'sd10;
    clut_we = 1'b0; clut_addr = 1'b1; clut_data = 12'hF00;
    tick();
    tick();
    check_eq("reset_rgb", rgb(), 0);
    check_eq("reset_addr", 32'(fb_addr), 0);
    check_eq("reset_hsync", 32'(vga_hs), 0);
    rst_pix_n = 1'b1;

    frame_pulse();
    for (int x = 0; x < 640; x++) begin
      pix(x, 0);
      hsync   = (x == 5);
      clut_we = (x == 13);
      if (x == 3)  check_eq("addr_y0_x3", 32'(fb_addr), 0);
      if (x == 4)  check_eq("addr_y0_x4", 32'(fb_addr), 1);
      if (x == 1)  check_eq("lat_before", rgb(), 0);
      if (x == 2)  check_eq("lat_pix0", rgb(), 'hFFF);
      if (x == 6)  check_eq("hsync_d1", 32'(vga_hs), 0);
      if (x == 7)  check_eq("hsync_d2", 32'(vga_hs), 1);
      if (x == 8)  check_eq("hsync_d3", 32'(vga_hs), 0);
      if (x == 14) check_eq("clut_same_cycle", rgb(), 'hFFF);
      if (x == 15) check_eq("clut_new", rgb(), 'hF00);
      tick();
    end
    hsync = 1'b0;
    clut_we = 1'b0;

    for (int y = 1; y < 480; y++) begin
      if (y == 200) pos_x = 16'sd100;
      if (y == 479) begin
        for (int x = 0; x < 640; x++) begin
          pix(x, y);
          if (x == 0)   check_eq("addr_y479_x0", 32'(fb_addr), 19040);
          if (x == 639) check_eq("addr_y479_x639", 32'(fb_addr), 19199);
          tick();
        end
      end else begin
        pix(0, y);
        if (y == 3) check_eq("addr_y3_x0", 32'(fb_addr), 0);
        if (y == 4) check_eq("addr_y4_x0", 32'(fb_addr), 160);
        if (y == 5) check_eq("clut_later_pixel", rgb(), 'hF00);
        tick();
        if (y == 201) begin
          for (int x = 1; x <= 4; x++) begin
            pix(x, y);
            if (x == 4) check_eq("pos_ignored_midframe", 32'(fb_addr), 8001);
            tick();
          end
        end
        pix(639, y);
        tick();
      end
    end

    frame_pulse();
    for (int x = 98; x < 106; x++) begin
      pix(x, 0);
      if (x == 100) check_eq("newpos_addr_x100", 32'(fb_addr), 0);
      if (x == 100) check_eq("newpos_bg_left", rgb(), 'h137);
      if (x == 104) check_eq("newpos_addr_x104", 32'(fb_addr), 1);
      if (x == 104) check_eq("newpos_pix", rgb(), 'hF00);
      tick();
    end
    pix(639, 0);
    tick();
    for (int y = 1; y < 50; y++) begin
      pix(100, y);
      tick();
      pix(639, y);
      tick();
    end

    pix(120, 50);
    rst_pix_n = 1'b0;
    tick();
    rst_pix_n = 1'b1;
    check_eq("rst_mid_rgb", rgb(), 0);
    check_eq("rst_mid_addr", 32'(fb_addr), 0);
    check_eq("rst_mid_hsync", 32'(vga_hs), 0);
    for (int x = 100; x <= 110; x++) begin
      pix(x, 50);
      if (x == 103) check_eq("unarmed_bg", rgb(), 'h137);
      if (x == 108) check_eq("unarmed_hold", 32'(fb_addr), 0);
      tick();
    end

    frame_pulse();
    for (int x = 98; x < 106; x++) begin
      pix(x, 0);
      if (x == 100) check_eq("rearm_addr_origin", 32'(fb_addr), 0);
      if (x == 102) check_eq("clut_reset_ramp", rgb(), 'hFFF);
      if (x == 104) check_eq("rearm_addr_x104", 32'(fb_addr), 1);
      tick();
    end

    frame_pulse();
    for (int x = 598; x < 640; x++) begin
      pix(x, 10);
      if (x == 600) check_eq("clip_addr_x600", 32'(fb_addr2), 0);
      if (x == 600) check_eq("clip_bg_x598", rgb2(), 'h137);
      if (x == 601) check_eq("clip_bg_x599", rgb2(), 'h137);
      if (x == 602) check_eq("clip_pix_x600", rgb2(), 'h000);
      if (x == 639) check_eq("clip_addr_x639", 32'(fb_addr2), 39);
      tick();
    end
    pix(600, 11);
    check_eq("clip_addr_next_row", 32'(fb_addr2), 160);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_scaled_reader.md
# fb_scaled_reader

Parametrised framebuffer display reader: the successor to the fixed 160×120 mono framebuffer path, generalised in bits per pixel, framebuffer size, integer upscale factor and on-screen position, with a writable colour lookup table (CLUT). Sits between the display timing generator and the VGA pins. It walks a simple-dual-port framebuffer BRAM read port, maps pixel values through the CLUT, and emits registered, latency-aligned VGA signals. Multiplier-free: all addressing uses counters.

## Interface

- CORDW, 16: signed coordinate width.
- CHANW, 4: colour channel width; COLRW = 3*CHANW.
- FB_WIDTH, 160: framebuffer width in pixels.
- FB_HEIGHT, 120: framebuffer height in pixels.
- FB_DATAW, 1: bits per pixel, legal range 1..8.
- SCALE, 4: integer upscale factor, legal range 1..8.
- H_RES, 640 / V_RES, 480: active display size.
- BRAM_LAT, 1: framebuffer read latency in cycles, legal range 1..2.
- BG_COLR, 'h137: colour outside the window.
- Illegal parameter values are an elaboration error. FB_ADDRW = $clog2(FB_WIDTH*FB_HEIGHT).

- clk_pix  in  1  pixel clock; the only clock.
- rst_pix_n  in  1  reset; synchronous, active-low.
- sx, sy  in  CORDW signed  screen coordinates from timing generator.
- hsync, vsync, de, frame  in  1  timing signals; frame pulses one cycle at frame start.
- pos_x, pos_y  in  CORDW signed  window top-left; legal range 0..H_RES-1 / 0..V_RES-1.
- fb_addr_read  out  FB_ADDRW  BRAM read address.
- fb_colr_read  in  FB_DATAW  BRAM read data, valid BRAM_LAT cycles after address.
- clut_we  in  1  CLUT write enable.
- clut_addr  in  FB_DATAW  CLUT write index.
- clut_data  in  COLRW  CLUT write data {r,g,b}.
- vga_hsync, vga_vsync  out  1  registered syncs.
- vga_r, vga_g, vga_b  out  CHANW  registered colour.

## Operation

- **Window:** in_win = sy in [py, py+FB_HEIGHT*SCALE) and sx in [px, px+FB_WIDTH*SCALE). Extents are computed at CORDW+1 bits so they cannot overflow.
- **Position latch:** px/py latch pos_x/pos_y on the cycle frame=1. Mid-frame changes to pos_x/pos_y are ignored until the next frame.
- **Armed flag:** cleared by reset, set by the first frame pulse. While unarmed, the paint colour is BG_COLR and counters hold.
- **Address state:** addr, line_base, cnt_x (0..SCALE-1), cnt_y (0..SCALE-1). fb_addr_read = addr, which is always the address of the pixel at the current (sx,sy).
- **On frame:** addr, line_base, cnt_x and cnt_y all go to 0.
- **In window, not last column:** cnt_x increments. When cnt_x = SCALE-1, cnt_x wraps to 0 and addr increments by 1.
- **Last column** (sx = px+FB_WIDTH*SCALE-1, or sx = H_RES-1 if that comes first, i.e. right clip): cnt_x goes to 0.
  - If cnt_y = SCALE-1: cnt_y goes to 0, and line_base and addr both become line_base+FB_WIDTH.
  - Otherwise: cnt_y increments and addr returns to line_base (line repeat).
- **Outside window:** all address state holds.
- **Bottom clip:** rows past V_RES are never reached; the next frame pulse resets the state.
- **CLUT:** 2^FB_DATAW entries × COLRW, register array.
  - Reset value: entry i = grey ramp, each channel = (i*(2^CHANW-1))/(2^FB_DATAW-1), truncated. For FB_DATAW=1 this gives 'h000 and 'hFFF.
  - A write takes effect for lookups from the next cycle. A same-cycle lookup of the entry being written returns the old value.
- **Paint:** colour = de_d ? (in_win_d & armed ? clut[fb_colr_read] : BG_COLR) : 0.

## Timing

- Pipeline latency from (sx,sy,hsync,vsync,de) to vga_* outputs is PIPE = BRAM_LAT+1 cycles.
- hsync, vsync, de and in_win are delayed by shift registers so that vga_* stay aligned with their pixel.
- The CLUT read is combinational from fb_colr_read and registered into vga_r/g/b.
- On a cycle with rst_pix_n=0, at the next edge:
  - vga_* = 0, fb_addr_read = 0;
  - all counters, px, py = 0;
  - delay lines = 0, armed = 0;
  - CLUT = grey ramp.
- Reset mid-line or mid-frame discards all state. Output is BG or black until the first frame after reset.
- frame and last column on the same cycle: the frame reset wins.
- clut_we is ignored during reset.

## Test plan

- **Address map, defaults, pos (0,0):** check fb_addr_read at these points.
  - sy=0, sx=0..3 -> 0; sx=4 -> 1.
  - sy=3, sx=0 -> 0.
  - sy=4, sx=0 -> 160.
  - sy=479, sx=639 -> 19199.
- **Latency:** BRAM model with BRAM_LAT=1, word 0 = 1, default CLUT. Pixel (0,0) -> vga_r/g/b = 'hF/'hF/'hF exactly 2 cycles later; vga_hsync aligned to hsync delayed by 2.
- **Right clip:** SCALE=1, pos (600,10). At sy=10, sx=639 -> addr 39; at sy=11, sx=600 -> addr 160. Pixels at sx<600 show 'h137.
- **CLUT write mid-frame:** clut_we with addr 1, data 'hF00. Later pixels whose value is 1 output r=F, g=0, b=0. Same-cycle lookup of entry 1 still shows 'hFFF.
- **Position change mid-frame:** pos_x 0->100 at sy=200. Rest of the frame still draws from sx=0; next frame starts at sx=100.
- **Reset mid-frame:** rst_pix_n low 1 cycle at sy=50. Next cycle vga_* = 0 and fb_addr_read = 0. Window shows BG_COLR until the next frame, then addr 0 at the window origin.
